// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: registers the redirect (PC load, target, IF/ID flush
// window, BL link write) for a branch resolved in ID and keeps taken/not-taken statistics.
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cond_true,
  input  logic             id_b,
  input  logic             id_l,
  input  logic [31:0]      id_pc,
  input  logic [23:0]      id_imm24,
  input  logic             stall,
  input  logic             stat_clr,
  output logic             pc_load,
  output logic [31:0]      target_addr,
  output logic             if_id_flush,
  output logic             link_we,
  output logic [31:0]      link_data,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Countdown preload: the first FLUSH cycle is counted by the state itself.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  logic [1:0]       flush_cnt_q;
  logic             pc_load_q;
  logic             link_we_q;
  logic             flush_q;
  logic [31:0]      target_q;
  logic [31:0]      link_q;
  logic [CNT_W-1:0] taken_cnt_q;
  logic [CNT_W-1:0] not_taken_cnt_q;

  logic             qualified;
  logic             taken_d;
  logic             not_taken_d;
  logic [31:0]      target_d;
  logic [31:0]      link_d;
  logic [CNT_W-1:0] taken_cnt_d;
  logic [CNT_W-1:0] not_taken_cnt_d;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    qualified   = (state_q == ST_IDLE) && id_b && !stall;
    taken_d     = qualified && cond_true;
    not_taken_d = qualified && !cond_true;
    target_d    = id_pc + 32'd8 + {{6{id_imm24[23]}}, id_imm24, 2'b00};
    link_d      = id_pc + 32'd4;
  end

  // stat_clr wins over a same-edge increment; counters stick at all-ones.
  always_comb begin
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    if (stat_clr) begin
      taken_cnt_d     = '0;
      not_taken_cnt_d = '0;
    end else begin
      if (taken_d && (taken_cnt_q != CNT_MAX)) begin
        taken_cnt_d = taken_cnt_q + CNT_ONE;
      end
      if (not_taken_d && (not_taken_cnt_q != CNT_MAX)) begin
        not_taken_cnt_d = not_taken_cnt_q + CNT_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 2'd0;
      pc_load_q   <= 1'b0;
      link_we_q   <= 1'b0;
      flush_q     <= 1'b0;
      target_q    <= 32'd0;
      link_q      <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (taken_d) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= FLUSH_LOAD;
            pc_load_q   <= 1'b1;
            link_we_q   <= id_l;
            flush_q     <= 1'b1;
            target_q    <= target_d;
            link_q      <= link_d;
          end else begin
            pc_load_q <= 1'b0;
            link_we_q <= 1'b0;
            flush_q   <= 1'b0;
          end
        end
        ST_FLUSH: begin
          // Redirect pulses only live in the first flush cycle; id_b is squashed here.
          pc_load_q <= 1'b0;
          link_we_q <= 1'b0;
          if (flush_cnt_q == 2'd0) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 2'd1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          pc_load_q <= 1'b0;
          link_we_q <= 1'b0;
          flush_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  assign pc_load       = pc_load_q;
  assign target_addr   = target_q;
  assign if_id_flush   = flush_q;
  assign busy          = flush_q;
  assign link_we       = link_we_q;
  assign link_data     = link_q;
  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Sequential branch-resolution stage directly downstream of the ID-stage condition evaluator. It consumes the evaluator's condition-true result for a branch sitting in ID. It then registers the redirect: PC load, target address, IF/ID flush window, and the BL link write. It also keeps taken/not-taken statistics counters for the pipeline debug bus.

Parameters:
FLUSH_CYCLES, 1, number of cycles if_id_flush stays asserted after a taken branch; legal range 1..3.
CNT_W, 16, width of each statistics counter.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
cond_true  input  1  condition-met result for the branch in ID; meaningful only when id_b=1
id_b  input  1  instruction in ID is a branch
id_l  input  1  link bit of the branch in ID (BL)
id_pc  input  32  address of the branch instruction in ID
id_imm24  input  24  signed word offset field of the branch
stall  input  1  hazard stall; ID is held this cycle
stat_clr  input  1  synchronous clear of both statistics counters
pc_load  output  1  one-cycle pulse: PC must load target_addr
target_addr  output  32  registered branch target
if_id_flush  output  1  squash the IF/ID register contents
link_we  output  1  one-cycle pulse: write link_data to R14
link_data  output  32  registered return address
busy  output  1  high while in FLUSH state
taken_cnt  output  CNT_W  taken-branch count, saturating
not_taken_cnt  output  CNT_W  not-taken-branch count, saturating

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, flush counter=0.
- All outputs go to 0 on reset, including target_addr, link_data, and both counters.
- Reset asserted mid-FLUSH aborts the flush immediately.
- Qualified branch: a clock edge where state=IDLE, id_b=1, and stall=0. No other condition qualifies.
- Ignored cases:
  - id_b with stall=1 is ignored; it is re-sampled on the next edge.
  - id_b while in FLUSH is ignored; it is a squashed instruction.
- Taken (qualified branch with cond_true=1), at the edge ending cycle N:
  - target_addr <= id_pc + 32'd8 + (sign_extend(id_imm24) << 2), computed modulo 2^32.
  - link_data <= id_pc + 32'd4, modulo 2^32.
  - In cycle N+1: pc_load=1, link_we=id_l (as sampled), if_id_flush=1, busy=1.
  - State goes to FLUSH, and taken_cnt increments.
- Not taken (qualified branch with cond_true=0):
  - not_taken_cnt increments.
  - No pc_load, flush, or link write; target_addr and link_data hold their previous values.
  - State stays IDLE.
- FSM:
  - IDLE -> FLUSH on a taken branch, loading flush counter=FLUSH_CYCLES-1.
  - FLUSH holds if_id_flush=1 and busy=1.
  - While the flush counter is nonzero it decrements each cycle; when it is 0, FLUSH -> IDLE on the next edge.
  - Net effect: if_id_flush is high for exactly FLUSH_CYCLES consecutive cycles.
- Pulse widths: pc_load and link_we are exactly one cycle, the first FLUSH cycle only. target_addr and link_data hold until the next taken branch.
- Latency: decision to redirect is 1 cycle. With FLUSH_CYCLES=1, a new branch can qualify in cycle N+2.
- Counters:
  - Each counter increments by 1 per qualifying event and saturates at all-ones (no wrap).
  - stat_clr=1 zeroes both counters on that edge and takes priority over a simultaneous increment.
- stall during FLUSH has no effect; the flush countdown continues.
- X on cond_true is irrelevant whenever id_b=0.

Test Plan:
1. Taken BL, forward offset: id_pc=0x00000100, id_imm24=0x000010, id_l=1, cond_true=1, stall=0.
   - Next cycle: pc_load=1, target_addr=0x00000148, link_we=1, link_data=0x00000104, if_id_flush=1; taken_cnt=1.
   - Following cycle: pc_load=0, link_we=0.
2. Taken B, negative offset and wrap:
   - id_pc=0x00000100, id_imm24=0xFFFFFE, id_l=0 -> target_addr=0x00000100, link_we=0.
   - id_pc=0xFFFFFFF8, id_imm24=0x000000 -> target_addr=0x00000000.
3. Not taken: id_b=1, cond_true=0 -> pc_load, if_id_flush, and link_we stay 0; not_taken_cnt=1; target_addr unchanged from prior value.
4. Stall and squash:
   - id_b=1, cond_true=1, stall=1 for 2 cycles then stall=0 -> exactly one pc_load, one cycle after stall deasserts.
   - With FLUSH_CYCLES=3, a second id_b=1, cond_true=1 during cycles 2-3 of the flush is ignored; taken_cnt advances by 1 only.
5. Reset mid-flush: FLUSH_CYCLES=3, taken branch, then reset_n=0 asynchronously in the 2nd flush cycle.
   - All outputs go to 0 immediately with no clock edge.
   - After release, the next taken branch behaves as in scenario 1.
6. Saturation and clear, with CNT_W=4:
   - 17 not-taken branches -> not_taken_cnt=0xF.
   - stat_clr=1 on the same edge as a taken branch -> both counters 0, while the branch still redirects (pc_load=1).
